// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the FSM encoding, PC width and the hazard-detect helper.
package pipe_ctrl_pkg;

    localparam int PC_W  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    // Canonical NOP (addi x0, x0, 0) loaded into a squashed stage register.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } ctrl_state_e;

    // A load in EX feeds a register that the ID instruction really reads; x0 never counts.
    function automatic logic load_use_hazard(
        input logic             exMemRead,
        input logic [REG_W-1:0] exRd,
        input logic [REG_W-1:0] idRs1,
        input logic [REG_W-1:0] idRs2,
        input logic             useRs1,
        input logic             useRs2
    );
        logic w_rs1Hit;
        logic w_rs2Hit;
        w_rs1Hit = useRs1 && (idRs1 == exRd);
        w_rs2Hit = useRs2 && (idRs2 == exRd);
        return exMemRead && (exRd != '0) && (w_rs1Hit || w_rs2Hit);
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running 32-bit event counter used for the debug performance counters.
// Counts one per enabled cycle and wraps silently at all-ones.
module ctrl_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: PC enable, IF/ID hold/flush and ID/EX bubble
// from load-use hazards, taken branches and data-memory wait, plus debug counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES    = 2,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             mem_busy,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic [PC_W-1:0]  ex_branch_target,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LSTALL_INIT = CNT_W'(LOAD_USE_CYCLES - 1);

    ctrl_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_hazard;
    logic w_stallEvt;
    logic w_flushEvt;

    assign w_hazard = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                      id_use_rs1, id_use_rs2);

    // Priority: reset > mem_busy > taken branch > current state > hazard.
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!sys_rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else if (ex_branch_taken) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_target;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                end
                ST_LSTALL: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    if (w_hazard) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // While mem_busy is high the whole pipe is frozen, so state and cnt simply hold.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (!mem_busy) begin
            if (ex_branch_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= FLUSH_INIT;
                end else begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            end else begin
                case (r_state)
                    ST_FLUSH, ST_LSTALL: begin
                        if (r_cnt <= 4'd1) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        if (w_hazard && (LOAD_USE_CYCLES > 1)) begin
                            r_state <= ST_LSTALL;
                            r_cnt   <= LSTALL_INIT;
                        end else begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign w_stallEvt = !pc_en;
    assign w_flushEvt = !mem_busy && ex_branch_taken;

    ctrl_perf_cnt #(.W(32)) u_stall_cnt (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .i_en    (w_stallEvt),
        .o_count (stall_cnt)
    );

    ctrl_perf_cnt #(.W(32)) u_flush_cnt (
        .clk     (sys_clk),
        .rst_n   (sys_rst),
        .i_en    (w_flushEvt),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with FLUSH_CYCLES=2, LOAD_USE_CYCLES=2.
// Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, redirect_valid}.
module tb_pipe_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic        mem_busy;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    logic [4:0] ctl;
    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_bubble, redirect_valid};

    pipe_ctrl #(.FLUSH_CYCLES(2), .LOAD_USE_CYCLES(2)) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .mem_busy         (mem_busy),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        mem_busy         = 1'b0;
        id_rs1           = 5'd0;
        id_rs2           = 5'd0;
        id_use_rs1       = 1'b0;
        id_use_rs2       = 1'b0;
        ex_mem_read      = 1'b0;
        ex_rd            = 5'd0;
        ex_branch_taken  = 1'b0;
        ex_branch_target = 32'h0;
    endtask

    task automatic setHazard();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd3;
        id_use_rs1  = 1'b1;
        id_rs2      = 5'd5;
        id_use_rs2  = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        idle();
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0400;
        repeat (3) step();
        checks++;
        if (ctl !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, 5'b00110);
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_redirect_pc: got %h expected %h", redirect_pc, 32'h0);
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
        end
        idle();
        sys_rst = 1'b1;
        step();
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL release_ctl: got %b expected %b", ctl, 5'b11000);
        end
    endtask

    task automatic test_load_use();
        setHazard();
        #1;
        checks++;
        if (ctl !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL lu_cycle0: got %b expected %b", ctl, 5'b00010);
        end
        step();
        checks++;
        if (ctl !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL lu_cycle1: got %b expected %b", ctl, 5'b00010);
        end
        step();
        idle();
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL lu_done: got %b expected %b", ctl, 5'b11000);
        end
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("[TB] FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, 2);
        end
        // Destination x0 never creates a hazard.
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs2  = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL lu_x0: got %b expected %b", ctl, 5'b11000);
        end
        // rs1 matches but is not used by the instruction.
        ex_rd      = 5'd7;
        id_rs1     = 5'd7;
        id_use_rs1 = 1'b0;
        id_rs2     = 5'd8;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL lu_unused_rs1: got %b expected %b", ctl, 5'b11000);
        end
        step();
        idle();
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("[TB] FAIL lu_no_stall_cnt: got %0d expected %0d", stall_cnt, 2);
        end
    endtask

    task automatic test_branch();
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0100;
        #1;
        checks++;
        if (ctl !== 5'b11111) begin
            errors++;
            $display("[TB] FAIL br_cycle0: got %b expected %b", ctl, 5'b11111);
        end
        checks++;
        if (redirect_pc !== 32'h0000_0100) begin
            errors++;
            $display("[TB] FAIL br_redirect_pc: got %h expected %h", redirect_pc, 32'h100);
        end
        step();
        idle();
        #1;
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL br_cycle1: got %b expected %b", ctl, 5'b11100);
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL br_pc_idle: got %h expected %h", redirect_pc, 32'h0);
        end
        step();
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL br_done: got %b expected %b", ctl, 5'b11000);
        end
        checks++;
        if (flush_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, 1);
        end
    endtask

    task automatic test_branch_in_lstall();
        setHazard();
        step();
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0200;
        #1;
        checks++;
        if ({ctl, redirect_pc} !== {5'b11111, 32'h0000_0200}) begin
            errors++;
            $display("[TB] FAIL bl_redirect: got %b/%h expected %b/%h",
                     ctl, redirect_pc, 5'b11111, 32'h200);
        end
        step();
        idle();
        #1;
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL bl_flush: got %b expected %b", ctl, 5'b11100);
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd3, 32'd2}) begin
            errors++;
            $display("[TB] FAIL bl_counters: got %0d/%0d expected 3/2", stall_cnt, flush_cnt);
        end
        step();
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL bl_run: got %b expected %b", ctl, 5'b11000);
        end
    endtask

    task automatic test_mem_busy_flush();
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0300;
        step();
        idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL mb_cycle%0d: got %b expected %b", i, ctl, 5'b00000);
            end
            step();
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL mb_resume_flush: got %b expected %b", ctl, 5'b11100);
        end
        checks++;
        if (stall_cnt !== 32'd7) begin
            errors++;
            $display("[TB] FAIL mb_stall_cnt: got %0d expected %0d", stall_cnt, 7);
        end
        step();
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL mb_run: got %b expected %b", ctl, 5'b11000);
        end
        // A branch under mem_busy is neither redirected nor counted.
        mem_busy         = 1'b1;
        ex_branch_taken  = 1'b1;
        ex_branch_target = 32'h0000_0500;
        #1;
        checks++;
        if ({ctl, redirect_pc} !== {5'b00000, 32'h0}) begin
            errors++;
            $display("[TB] FAIL mb_branch: got %b/%h expected %b/%h", ctl, redirect_pc, 5'b00000, 32'h0);
        end
        step();
        idle();
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd8, 32'd3}) begin
            errors++;
            $display("[TB] FAIL mb_counters: got %0d/%0d expected 8/3", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_stall_wrap();
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.r_count;
        #1;
        checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: got %h expected %h", stall_cnt, 32'hFFFF_FFFF);
        end
        mem_busy = 1'b1;
        step();
        mem_busy = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_stall_cnt: got %h expected %h", stall_cnt, 32'h0);
        end
    endtask

    task automatic test_reset_abort();
        setHazard();
        step();
        sys_rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL rst_abort_ctl: got %b expected %b", ctl, 5'b00110);
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL rst_abort_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
        end
        step();
        idle();
        sys_rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL rst_abort_run: got %b expected %b", ctl, 5'b11000);
        end
    endtask

    initial begin
        sys_rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_branch_in_lstall();
        test_mem_busy_flush();
        test_stall_wrap();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
